id_ctrl_pipe: RTL and testbench
===============================

# id_ctrl_pipe

Parametrised successor to the ID-stage control decoder for the 5-stage MIPS pipeline. It decodes `opcode`/`funct` into the RegDst/WB/MEM/EX control bundles and registers them into the ID/EX boundary. It handles flush bubbles and external stall holds. It also tracks the multi-cycle mult/div unit and stalls dependent HI/LO instructions until the unit is done.

## Interface

Parameters:
- `MULT_CYCLES`, default 4: cycles the HI/LO unit is busy after a `mult` issues (≥1).
- `DIV_CYCLES`, default 32: cycles busy after a `div` issues (≥1).
- `CNT_W`, default `$clog2(max(MULT_CYCLES,DIV_CYCLES)+1)`: busy-counter width.

Ports:
- `CLK` in 1: clock.
- `RESET` in 1: synchronous, active-high reset.
- `ID_Valid` in 1: ID stage holds a real instruction.
- `opcode` in 6: instruction[31:26].
- `funct` in 6: instruction[5:0].
- `Flush` in 1: kill the ID instruction (branch/jump redirect).
- `Stall_in` in 1: external pipeline freeze (memory/load-use).
- `Jump` out 2: combinational. 00 none, 01 j/jal, 10 jr.
- `Stall` out 2→1: combinational. Asserted when a HI/LO hazard blocks issue.
- `EX_Valid` out 1: registered ID/EX valid.
- `EX_RegDst` out 2: registered. 00 rt, 01 rd, 10 $ra.
- `EX_WB` out 3: registered. {MemtoReg[1:0] (00 ALU, 01 mem, 10 PC link), RegWrite}.
- `EX_MEM` out 2: registered. {MemRead, MemWrite}.
- `EX_EX` out 6: registered. {ALUOp[2:0], ALUSrc, HiLo[1:0]}.
- `HiLo_Busy` out 1: registered. Busy counter is nonzero.
- `Illegal` out 1: registered one-cycle pulse. An undecodable opcode issued.

## Operation

- **Decode table** (combinational, zero latency):
  - R default: RegDst 01, EX 001000, MEM 00, WB 001.
  - `jr`: Jump 10. `mult`/`div`: RegWrite 0. `mfhi`: HiLo 10. `mflo`: HiLo 01.
  - `j`: Jump 01, ALUOp 111, WB 000.
  - `jal`: Jump 01, RegDst 10, WB 101, ALUOp 111.
  - `addi`/`andi`/`ori`/`slti`: RegDst 00, ALUSrc 1, WB 001, ALUOp 000/010/011/110.
  - `beq`/`bne`: ALUOp 100/101, WB 000.
  - `lw`: RegDst 00, ALUSrc 1, MEM 10, WB 011.
  - `sw`: ALUSrc 1, MEM 01, WB 000.
  - Any other opcode: all-zero bundle and `Illegal` candidate.
- **Bubble**: all registered bundles 0 and `EX_Valid` 0.
- **HI/LO hazard**: `Stall` = `ID_Valid & HiLo_Busy & (mfhi|mflo|mult|div)`.
- **Issue**: `issue` = `ID_Valid & ~Stall & ~Stall_in & ~Flush`.
- **ID/EX register priority** (per cycle):
  1. `RESET`: bubble.
  2. `Flush`: bubble.
  3. `Stall_in`: hold all ID/EX registers.
  4. `Stall` or `~ID_Valid`: bubble.
  5. Otherwise: load the decoded bundle, `EX_Valid` = 1.
- **Jump gating**: `Jump` is forced to 00 when `~ID_Valid | Stall | Stall_in | Flush`.
- **Busy FSM**: two states, IDLE (cnt == 0) and BUSY (cnt != 0).
  - `issue` of `mult` loads `MULT_CYCLES`; `issue` of `div` loads `DIV_CYCLES`.
  - Otherwise cnt decrements while nonzero.
  - cnt decrements regardless of `Stall_in` or `Flush`.
  - `HiLo_Busy` = (cnt != 0).
- **`Illegal`**: pulses the cycle after an `issue` of an undecodable opcode.

## Timing

- **Reset values**: all `EX_*` 0, `HiLo_Busy` 0, `Illegal` 0, cnt 0. A `RESET` asserted mid-busy clears cnt on that edge.
- **Latency**: decode to `EX_*` is 1 cycle. `Jump`/`Stall` are same-cycle combinational.
- **Hazard duration**: `mfhi` directly following `mult` sees `Stall` for exactly `MULT_CYCLES` cycles and issues on the next cycle.
- **Flush vs. issue**: `Flush` in the same cycle as a `mult`/`div` in ID means the counter is not loaded.
- **Combined stalls**: `Stall` and `Stall_in` together means hold (`Stall_in` wins over bubble).
- **Counter wrap**: the counter saturates at 0 and never wraps.

## Configuration

- **`ID_CTRL_JALR_EN` defined**: R `funct` 001001 (`jalr`) decodes to Jump 10, RegDst 01, WB 101, ALUOp 111.
- **`ID_CTRL_JALR_EN` not defined**: that funct decodes as the R default.

## Structure

- **Package `ctrl_pkg`**:
  - opcode/funct localparams.
  - Jump, RegDst, MemtoReg and ALUOp encodings.
  - Bubble-bundle constant.
- **Sub-module `ctrl_decode`**: pure combinational table producing the bundle plus `is_muldiv` and `is_hilo_read`.
- **Top**: holds the ID/EX registers, busy counter, and gating.

## Test plan

1. `RESET` for 2 cycles, then `addi` valid → next cycle `EX_RegDst`=00, `EX_EX`=000100, `EX_WB`=001, `EX_Valid`=1.
2. `mult`, then `mflo` held valid (`MULT_CYCLES`=4) → `Stall`=1 for 4 cycles with `EX_Valid`=0 bubbles; `mflo` reaches EX with `EX_EX`=001001 on the 5th cycle.
3. `div` (`DIV_CYCLES`=32), `RESET` on cycle 10 → `HiLo_Busy`=0 next cycle; a following `mfhi` issues without stall.
4. `lw` with `Stall_in`=1 for 3 cycles after a prior `sw` in EX → `EX_MEM` holds 01 for 3 cycles, then becomes 10.
5. `jal` with `Flush`=1 → `Jump`=00 and a bubble. `jal` without flush → `Jump`=01, then `EX_RegDst`=10, `EX_WB`=101.
6. Opcode 111111 valid → `Illegal` pulses 1 cycle, bundle all zero. With `ID_CTRL_JALR_EN`, `jalr` → `Jump`=10, `EX_WB`=101.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ID-stage control encodings, opcode/funct values and control bundle types.
package ctrl_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;

  // Opcodes (instruction[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type funct codes (instruction[5:0])
  localparam logic [FN_W-1:0] FN_JR    = 6'b001000;
  localparam logic [FN_W-1:0] FN_JALR  = 6'b001001;
  localparam logic [FN_W-1:0] FN_MFHI  = 6'b010000;
  localparam logic [FN_W-1:0] FN_MFLO  = 6'b010010;
  localparam logic [FN_W-1:0] FN_MULT  = 6'b011000;
  localparam logic [FN_W-1:0] FN_DIV   = 6'b011010;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_REG  = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MTR_ALU   = 2'b00;
  localparam logic [1:0] MTR_MEM   = 2'b01;
  localparam logic [1:0] MTR_LINK  = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_RTYPE = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_BEQ   = 3'b100;
  localparam logic [2:0] ALU_BNE   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;
  localparam logic [2:0] ALU_JUMP  = 3'b111;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_LO   = 2'b01;
  localparam logic [1:0] HILO_HI   = 2'b10;

  typedef struct packed {
    logic [1:0] memtoreg;
    logic       regwrite;
  } wb_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
  } mem_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc;
    logic [1:0] hilo;
  } ex_t;

  typedef struct packed {
    logic [1:0] jump;
    logic [1:0] regdst;
    wb_t        wb;
    mem_t       mem;
    ex_t        ex;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decode table. Optional macro: ID_CTRL_JALR_EN
// enables the jalr funct decode; otherwise that funct falls to the R default.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  output ctrl_t           ctrl,
  output logic            is_muldiv,
  output logic            is_hilo_read,
  output logic            illegal
);

  // Decode table: start from an all-zero bundle, then fill per instruction
  always_comb begin
    ctrl         = CTRL_BUBBLE;
    is_muldiv    = 1'b0;
    is_hilo_read = 1'b0;
    illegal      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regdst      = REGDST_RD;
        ctrl.ex.aluop    = ALU_RTYPE;
        ctrl.wb.memtoreg = MTR_ALU;
        ctrl.wb.regwrite = 1'b1;
        case (funct)
          FN_JR:   ctrl.jump = JUMP_REG;
          FN_MULT,
          FN_DIV: begin
            ctrl.wb.regwrite = 1'b0;
            is_muldiv        = 1'b1;
          end
          FN_MFHI: begin
            ctrl.ex.hilo = HILO_HI;
            is_hilo_read = 1'b1;
          end
          FN_MFLO: begin
            ctrl.ex.hilo = HILO_LO;
            is_hilo_read = 1'b1;
          end
`ifdef ID_CTRL_JALR_EN
          FN_JALR: begin
            ctrl.jump        = JUMP_REG;
            ctrl.wb.memtoreg = MTR_LINK;
            ctrl.ex.aluop    = ALU_JUMP;
          end
`endif
          default: ;
        endcase
      end
      OP_J: begin
        ctrl.jump     = JUMP_J;
        ctrl.ex.aluop = ALU_JUMP;
      end
      OP_JAL: begin
        ctrl.jump        = JUMP_J;
        ctrl.regdst      = REGDST_RA;
        ctrl.wb.memtoreg = MTR_LINK;
        ctrl.wb.regwrite = 1'b1;
        ctrl.ex.aluop    = ALU_JUMP;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl.regdst      = REGDST_RT;
        ctrl.ex.alusrc   = 1'b1;
        ctrl.wb.regwrite = 1'b1;
        case (opcode)
          OP_ANDI: ctrl.ex.aluop = ALU_AND;
          OP_ORI:  ctrl.ex.aluop = ALU_OR;
          OP_SLTI: ctrl.ex.aluop = ALU_SLT;
          default: ctrl.ex.aluop = ALU_ADD;
        endcase
      end
      OP_BEQ: ctrl.ex.aluop = ALU_BEQ;
      OP_BNE: ctrl.ex.aluop = ALU_BNE;
      OP_LW: begin
        ctrl.regdst      = REGDST_RT;
        ctrl.ex.alusrc   = 1'b1;
        ctrl.mem.memread = 1'b1;
        ctrl.wb.memtoreg = MTR_MEM;
        ctrl.wb.regwrite = 1'b1;
      end
      OP_SW: begin
        ctrl.ex.alusrc    = 1'b1;
        ctrl.mem.memwrite = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID/EX control register stage with flush/stall gating and HI/LO busy tracking.
// Optional macro: ID_CTRL_JALR_EN (jalr decode, handled in ctrl_decode).
module id_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       =
    $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1)
)(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ID_Valid,
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  input  logic            Flush,
  input  logic            Stall_in,
  output logic [1:0]      Jump,
  output logic            Stall,
  output logic            EX_Valid,
  output logic [1:0]      EX_RegDst,
  output logic [2:0]      EX_WB,
  output logic [1:0]      EX_MEM,
  output logic [5:0]      EX_EX,
  output logic            HiLo_Busy,
  output logic            Illegal
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} busy_state_t;

  ctrl_t            dec;
  logic             is_muldiv;
  logic             is_hilo_read;
  logic             dec_illegal;
  logic             issue;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  busy_state_t      state;

  ctrl_decode u_decode (
    .opcode       (opcode),
    .funct        (funct),
    .ctrl         (dec),
    .is_muldiv    (is_muldiv),
    .is_hilo_read (is_hilo_read),
    .illegal      (dec_illegal)
  );

  // Hazard, issue qualification and gated jump select
  assign Stall    = ID_Valid & HiLo_Busy & (is_muldiv | is_hilo_read);
  assign issue    = ID_Valid & ~Stall & ~Stall_in & ~Flush;
  assign Jump     = issue ? dec.jump : JUMP_NONE;
  assign load_val = (funct == FN_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // ID/EX register: reset > flush > external hold > hazard/empty bubble > load
  always_ff @(posedge CLK) begin
    if (RESET || Flush) begin
      EX_Valid  <= 1'b0;
      EX_RegDst <= '0;
      EX_WB     <= '0;
      EX_MEM    <= '0;
      EX_EX     <= '0;
      Illegal   <= 1'b0;
    end else if (Stall_in) begin
      Illegal   <= 1'b0;
    end else if (Stall || !ID_Valid) begin
      EX_Valid  <= 1'b0;
      EX_RegDst <= '0;
      EX_WB     <= '0;
      EX_MEM    <= '0;
      EX_EX     <= '0;
      Illegal   <= 1'b0;
    end else begin
      EX_Valid  <= 1'b1;
      EX_RegDst <= dec.regdst;
      EX_WB     <= dec.wb;
      EX_MEM    <= dec.mem;
      EX_EX     <= dec.ex;
      Illegal   <= dec_illegal;
    end
  end

  // HI/LO busy FSM: load on mult/div issue, count down to zero otherwise
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      HiLo_Busy <= 1'b0;
    end else if (issue && is_muldiv) begin
      state     <= ST_BUSY;
      cnt       <= load_val;
      HiLo_Busy <= 1'b1;
    end else begin
      case (state)
        ST_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= ST_IDLE;
            HiLo_Busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Scoreboard bench for id_ctrl_pipe: directed scenarios then random traffic,
// checked against a cycle-level behavioural model.
module tb_id_ctrl_pipe;

  localparam int unsigned MC = 4;
  localparam int unsigned DC = 32;

  logic       CLK, RESET, ID_Valid, Flush, Stall_in;
  logic [5:0] opcode, funct;
  logic [1:0] Jump;
  logic       Stall, EX_Valid, HiLo_Busy, Illegal;
  logic [1:0] EX_RegDst, EX_MEM;
  logic [2:0] EX_WB;
  logic [5:0] EX_EX;

  id_ctrl_pipe #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .CLK(CLK), .RESET(RESET), .ID_Valid(ID_Valid), .opcode(opcode), .funct(funct),
    .Flush(Flush), .Stall_in(Stall_in), .Jump(Jump), .Stall(Stall),
    .EX_Valid(EX_Valid), .EX_RegDst(EX_RegDst), .EX_WB(EX_WB), .EX_MEM(EX_MEM),
    .EX_EX(EX_EX), .HiLo_Busy(HiLo_Busy), .Illegal(Illegal)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [1:0] j;
    logic [1:0] rd;
    logic [2:0] wb;
    logic [1:0] mem;
    logic [5:0] ex;
    bit ill;
    bit mul;
    bit dv;
    bit hrd;
  } ref_t;

  // Expected registered view after an edge: {valid, regdst, wb, mem, ex, busy, illegal}
  logic [15:0] expq[$];

  int total = 0;
  int bad   = 0;

  // Model state
  bit         m_ev;
  logic [1:0] m_rd, m_mem;
  logic [2:0] m_wb;
  logic [5:0] m_ex;
  int         m_busy;
  bit         m_ill;

  function automatic ref_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
    ref_t r;
    r = '{j:2'b00, rd:2'b00, wb:3'b000, mem:2'b00, ex:6'b000000, ill:0, mul:0, dv:0, hrd:0};
    case (op)
      6'h00: begin
        {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b00, 2'b01, 3'b001, 2'b00, 6'b001000};
        case (fn)
          6'h08: r.j = 2'b10;
          6'h18: begin r.wb = 3'b000; r.mul = 1; end
          6'h1A: begin r.wb = 3'b000; r.dv = 1; end
          6'h10: begin r.ex = 6'b001010; r.hrd = 1; end
          6'h12: begin r.ex = 6'b001001; r.hrd = 1; end
`ifdef ID_CTRL_JALR_EN
          6'h09: {r.j, r.rd, r.wb, r.ex} = {2'b10, 2'b01, 3'b101, 6'b111000};
`endif
          default: ;
        endcase
      end
      6'h02: {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b01, 2'b00, 3'b000, 2'b00, 6'b111000};
      6'h03: {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b01, 2'b10, 3'b101, 2'b00, 6'b111000};
      6'h08: {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b00, 2'b00, 3'b001, 2'b00, 6'b000100};
      6'h0C: {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b00, 2'b00, 3'b001, 2'b00, 6'b010100};
      6'h0D: {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b00, 2'b00, 3'b001, 2'b00, 6'b011100};
      6'h0A: {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b00, 2'b00, 3'b001, 2'b00, 6'b110100};
      6'h04: {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b00, 2'b00, 3'b000, 2'b00, 6'b100000};
      6'h05: {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b00, 2'b00, 3'b000, 2'b00, 6'b101000};
      6'h23: {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b00, 2'b00, 3'b011, 2'b10, 6'b000100};
      6'h2B: {r.j, r.rd, r.wb, r.mem, r.ex} = {2'b00, 2'b00, 3'b000, 2'b01, 6'b000100};
      default: r.ill = 1;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One ID-stage cycle: drive, check combinational outputs, advance the model
  task automatic cyc(input bit rst, input bit v, input logic [5:0] op, input logic [5:0] fn,
                     input bit fl, input bit si, output bit stall_seen);
    ref_t r;
    bit st, iss;
    @(negedge CLK);
    RESET = rst; ID_Valid = v; opcode = op; funct = fn; Flush = fl; Stall_in = si;
    #1;
    r   = ref_decode(op, fn);
    st  = v && (m_busy > 0) && (r.mul || r.dv || r.hrd);
    iss = v && !st && !si && !fl;
    chk("stall", {31'd0, Stall}, {31'd0, st});
    chk("jump", {30'd0, Jump}, {30'd0, (iss ? r.j : 2'b00)});
    stall_seen = Stall;
    if (rst) begin
      m_ev = 0; m_rd = 0; m_wb = 0; m_mem = 0; m_ex = 0; m_busy = 0; m_ill = 0;
    end else begin
      if (iss && r.mul)      m_busy = MC;
      else if (iss && r.dv)  m_busy = DC;
      else if (m_busy > 0)   m_busy = m_busy - 1;
      m_ill = iss && r.ill;
      if (fl || (!si && (st || !v))) begin
        m_ev = 0; m_rd = 0; m_wb = 0; m_mem = 0; m_ex = 0;
      end else if (!si) begin
        m_ev = 1; m_rd = r.rd; m_wb = r.wb; m_mem = r.mem; m_ex = r.ex;
      end
    end
    expq.push_back({m_ev, m_rd, m_wb, m_mem, m_ex, (m_busy > 0), m_ill});
  endtask

  // Monitor: compare the registered ID/EX view after every active edge
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("idex", {16'd0, EX_Valid, EX_RegDst, EX_WB, EX_MEM, EX_EX, HiLo_Busy, Illegal},
            {16'd0, e});
      end
    end
  end

  initial begin
    bit s;
    int n;
    logic [5:0] ops[12];
    logic [5:0] fns[8];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h04, 6'h23, 6'h2B};
    fns = '{6'h08, 6'h09, 6'h10, 6'h12, 6'h18, 6'h1A, 6'h20, 6'h2A};
    m_ev = 0; m_rd = 0; m_wb = 0; m_mem = 0; m_ex = 0; m_busy = 0; m_ill = 0;
    RESET = 1; ID_Valid = 0; opcode = 0; funct = 0; Flush = 0; Stall_in = 0;

    // Reset, then addi
    cyc(1, 0, 0, 0, 0, 0, s);
    cyc(1, 0, 0, 0, 0, 0, s);
    cyc(0, 1, 6'h08, 0, 0, 0, s);
    cyc(0, 0, 0, 0, 0, 0, s);

    // mult then mflo held: stall must last exactly MC cycles
    cyc(0, 1, 6'h00, 6'h18, 0, 0, s);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 6'h00, 6'h12, 0, 0, s);
      if (!s) break;
      n++;
    end
    chk("mflo_stall_len", n, MC);
    cyc(0, 0, 0, 0, 0, 0, s);

    // div, reset mid-busy, then mfhi issues unstalled
    cyc(0, 1, 6'h00, 6'h1A, 0, 0, s);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 0, s);
    cyc(1, 0, 0, 0, 0, 0, s);
    cyc(0, 1, 6'h00, 6'h10, 0, 0, s);
    chk("mfhi_after_reset", {31'd0, s}, 32'd0);

    // sw then lw under external hold for 3 cycles
    cyc(0, 1, 6'h2B, 0, 0, 0, s);
    for (int i = 0; i < 3; i++) cyc(0, 1, 6'h23, 0, 0, 1, s);
    cyc(0, 1, 6'h23, 0, 0, 0, s);

    // jal flushed, then jal issued
    cyc(0, 1, 6'h03, 0, 1, 0, s);
    cyc(0, 1, 6'h03, 0, 0, 0, s);

    // Illegal opcode, and the jalr funct
    cyc(0, 1, 6'h3F, 0, 0, 0, s);
    cyc(0, 1, 6'h00, 6'h09, 0, 0, s);

    // mult in ID with flush must not load the counter; combined stalls hold
    cyc(0, 1, 6'h00, 6'h18, 1, 0, s);
    cyc(0, 1, 6'h00, 6'h10, 0, 0, s);
    cyc(0, 1, 6'h00, 6'h18, 0, 0, s);
    cyc(0, 1, 6'h00, 6'h10, 0, 1, s);
    cyc(0, 1, 6'h00, 6'h10, 0, 1, s);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      else fn = fns[$urandom_range(0, 7)];
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8), op, fn,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0), s);
    end

    cyc(0, 0, 0, 0, 0, 0, s);
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
